// File: rtl/terminal_hex_dumper_pkg.sv
// Shared definitions for the text-terminal hex dump engine and the debugger
// that drives the same terminal write port.
package terminal_hex_dumper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_EMIT,
    ST_DONE
  } dump_state_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) return ASCII_ZERO + {4'd0, nibble};
    else                return ASCII_A + {4'd0, nibble} - 8'd10;
  endfunction

endpackage

// File: rtl/terminal_hex_dumper.sv
// Snapshots a flat vector of words and writes them into the terminal text
// buffer as uppercase hex, one character per clock, with change highlighting.
module terminal_hex_dumper
  import terminal_hex_dumper_pkg::*;
#(
  parameter int          WORDS          = 32,
  parameter int          WORD_WIDTH     = 32,
  parameter int          WORDS_PER_LINE = 4,
  parameter int          COLUMNS        = 80,
  parameter int          ADDR_WIDTH     = 12,
  parameter int unsigned BASE_ADDR      = 0,
  parameter bit          HIGHLIGHT      = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [WORDS*WORD_WIDTH-1:0] words,
  input  logic                        start,
  input  logic                        auto_refresh,
  output logic [ADDR_WIDTH-1:0]       terminal_addr,
  output logic                        terminal_write,
  output logic [7:0]                  terminal_data,
  output logic                        busy,
  output logic                        done
);

  localparam int DIGITS   = WORD_WIDTH / 4;
  localparam int WORD_CW  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int DIGIT_CW = $clog2(DIGITS + 1);
  localparam int COL_CW   = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam int LW_CW    = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(COLUMNS);

  if (WORD_WIDTH % 4 != 0) begin : g_bad_word_width
    $error("terminal_hex_dumper: WORD_WIDTH must be a multiple of 4");
  end
  if (WORDS_PER_LINE * (DIGITS + 1) > COLUMNS) begin : g_bad_line_fit
    $error("terminal_hex_dumper: WORDS_PER_LINE*(DIGITS+1) exceeds COLUMNS");
  end

  dump_state_e                 state_q;
  logic [WORDS*WORD_WIDTH-1:0] shadow_q, prev_q;
  logic                        first_pass_q;
  logic [WORD_CW-1:0]          word_q, word_d;
  logic [DIGIT_CW-1:0]         digit_q, digit_d;
  logic [COL_CW-1:0]           col_q, col_d;
  logic [LW_CW-1:0]            line_word_q, line_word_d;
  logic [ADDR_WIDTH-1:0]       line_base_q, line_base_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic                        write_q, busy_q, done_q;
  logic [7:0]                  data_q, char_d;

  logic [WORDS*WORD_WIDTH-1:0] src_vec, ref_vec;
  logic [WORD_WIDTH-1:0]       cur_word, ref_word;
  logic [DIGIT_CW-1:0]         nib_sel;
  logic [3:0]                  nibble;
  logic                        last_char;

  // Position and character of the next write. CAPTURE emits the first
  // character straight from the input, since shadow is loaded on that edge.
  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred.
    word_d      = word_q;
    digit_d     = digit_q;
    col_d       = col_q;
    line_word_d = line_word_q;
    line_base_d = line_base_q;
    nibble      = 4'd0;

    if (state_q == ST_CAPTURE) begin
      word_d      = '0;
      digit_d     = '0;
      col_d       = '0;
      line_word_d = '0;
      line_base_d = BASE;
    end else if (digit_q == DIGIT_CW'(DIGITS)) begin
      digit_d = '0;
      word_d  = word_q + 1'b1;
      if (line_word_q == LW_CW'(WORDS_PER_LINE - 1)) begin
        line_word_d = '0;
        col_d       = '0;
        line_base_d = line_base_q + LINE_STEP;
      end else begin
        line_word_d = line_word_q + 1'b1;
        col_d       = col_q + 1'b1;
      end
    end else begin
      digit_d = digit_q + 1'b1;
      col_d   = col_q + 1'b1;
    end

    src_vec  = (state_q == ST_CAPTURE) ? words : shadow_q;
    ref_vec  = (state_q == ST_CAPTURE) ? shadow_q : prev_q;
    cur_word = src_vec[word_d*WORD_WIDTH +: WORD_WIDTH];
    ref_word = ref_vec[word_d*WORD_WIDTH +: WORD_WIDTH];

    nib_sel = DIGIT_CW'(DIGITS - 1) - digit_d;
    if (digit_d != DIGIT_CW'(DIGITS)) nibble = cur_word[{nib_sel, 2'b00} +: 4];

    char_d = (digit_d == DIGIT_CW'(DIGITS)) ? ASCII_SPACE : nibble_to_ascii(nibble);
    if (HIGHLIGHT && !first_pass_q && (cur_word != ref_word)) char_d[7] = 1'b1;

    addr_d    = line_base_d + ADDR_WIDTH'(col_d);
    last_char = (word_q == WORD_CW'(WORDS - 1)) && (digit_q == DIGIT_CW'(DIGITS));
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments throughout so every register updates from pre-edge values.
    if (!reset) begin
      state_q      <= ST_IDLE;
      // NOTE: shadow/prev are reset because change highlighting compares against them.
      shadow_q     <= '0;
      prev_q       <= '0;
      first_pass_q <= 1'b1;
      word_q       <= '0;
      digit_q      <= '0;
      col_q        <= '0;
      line_word_q  <= '0;
      line_base_q  <= '0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          write_q <= 1'b0;
          done_q  <= 1'b0;
          if (start || auto_refresh) begin
            state_q <= ST_CAPTURE;
            busy_q  <= 1'b1;
          end
        end
        ST_CAPTURE, ST_EMIT: begin
          if (state_q == ST_EMIT && last_char) begin
            state_q <= ST_DONE;
            write_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            if (state_q == ST_CAPTURE) begin
              prev_q   <= shadow_q;
              shadow_q <= words;
              state_q  <= ST_EMIT;
            end
            word_q      <= word_d;
            digit_q     <= digit_d;
            col_q       <= col_d;
            line_word_q <= line_word_d;
            line_base_q <= line_base_d;
            addr_q      <= addr_d;
            data_q      <= char_d;
            write_q     <= 1'b1;
          end
        end
        ST_DONE: begin
          done_q       <= 1'b0;
          first_pass_q <= 1'b0;
          if (auto_refresh) begin
            state_q <= ST_CAPTURE;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign terminal_addr  = addr_q;
  assign terminal_write = write_q;
  assign terminal_data  = data_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: doc/terminal_hex_dumper.md
# terminal_hex_dumper

Parametrised register/memory dump engine for the on-board text terminal. It snapshots a flat vector of N words and writes them into the terminal text buffer as uppercase hex, one character per clock, using the same write port the debugger drives (address, write strobe, 8-bit data). It generalises the fixed-layout debug dump in word count, word width, layout and base address. It adds a one-shot or auto-refresh mode and optional change highlighting (bit 7 of the character set when a word differs from the previous dump).

## Interface
- WORDS, 32: number of words dumped
- WORD_WIDTH, 32: bits per word; must be a multiple of 4; DIGITS = WORD_WIDTH/4
- WORDS_PER_LINE, 4: words per text row; WORDS_PER_LINE*(DIGITS+1) ≤ COLUMNS
- COLUMNS, 80: characters per terminal row
- ADDR_WIDTH, 12: terminal address width
- BASE_ADDR, 0: text address of the first character
- HIGHLIGHT, 1: 1 enables change highlighting, 0 forces bit 7 to 0

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-low (asserted when 0)
- words  in  WORDS*WORD_WIDTH  word i = words[i*WORD_WIDTH +: WORD_WIDTH]
- start  in  1  level-sampled request; honoured only in IDLE
- auto_refresh  in  1  when 1, a new dump begins immediately after each completes
- terminal_addr  out  ADDR_WIDTH  text buffer address
- terminal_write  out  1  write strobe, one character per high cycle
- terminal_data  out  8  ASCII character, bit 7 = highlight
- busy  out  1  high from CAPTURE through DONE
- done  out  1  one-cycle pulse when the last character has been written

## Operation
- FSM states: IDLE, CAPTURE, EMIT, DONE.
- IDLE -> CAPTURE when start=1 or auto_refresh=1.
- CAPTURE (1 cycle):
  - prev <= shadow; shadow <= words.
  - Clear word, digit and column counters; line_base <= BASE_ADDR.
- EMIT: one character per cycle per word, in word order 0..WORDS-1.
  - DIGITS hex digits, most significant nibble first, then one space (0x20).
  - Hex digit 0–9 -> 0x30–0x39; 10–15 -> 0x41–0x46.
- Addressing: character address = line_base + column.
  - After the space of every WORDS_PER_LINE-th word: line_base += COLUMNS, column <= 0.
  - No multiplier. All address arithmetic is modulo 2^ADDR_WIDTH.
- Highlight: for word i, all DIGITS+1 characters get bit 7 set when HIGHLIGHT=1, shadow[i] != prev[i], and first_pass=0.
  - first_pass is set by reset and cleared at the end of the first DONE.
- EMIT -> DONE after the last character of word WORDS-1.
- DONE (1 cycle): done=1.
  - Next state is CAPTURE if auto_refresh=1, else IDLE.
- start while busy is ignored and not queued.
- words is sampled only in CAPTURE. Changes during EMIT do not affect the current dump.

## Timing
- All outputs are registered.
- Reset values: terminal_addr=0, terminal_write=0, terminal_data=0, busy=0, done=0, state=IDLE, shadow=0, prev=0, first_pass=1.
- start high in cycle 0 produces:
  - CAPTURE with busy=1 in cycle 1;
  - terminal_write=1 in cycles 2 .. 1+N, where N = WORDS*(DIGITS+1);
  - DONE with done=1, busy=1, terminal_write=0 in cycle 2+N.
- Auto-refresh: CAPTURE follows DONE directly, so the period is N+2 cycles.
- Reset asserted mid-dump: all outputs are at their reset values on the next cycle, and the dump is abandoned.
- terminal_write is never high outside EMIT.

## Structure
- Shared package holds:
  - state enum;
  - ASCII constants (space, '0', 'A');
  - function nibble_to_ascii(4-bit) -> 8-bit.
- The package is reused by the existing debugger.
- No sub-module. Nibble select is an indexed part-select of the shadow word by the digit counter.
- Elaboration-time checks on the WORD_WIDTH%4 and line-fit constraints.

## Test plan
- Basic layout: WORDS=2, WORD_WIDTH=8, WORDS_PER_LINE=1, BASE_ADDR=0x100, word0=0x3C, word1=0x5A, start pulse.
  - Writes (0x100,0x33), (0x101,0x43), (0x102,0x20), (0x150,0x35), (0x151,0x41), (0x152,0x20) in cycles 2–7.
  - done in cycle 8.
- Highlight: repeat the dump with word1=0x5B.
  - word0 chars 0x33,0x43,0x20.
  - word1 chars 0xB5,0xC2,0xA0.
  - With HIGHLIGHT=0, word1 chars are 0x35,0x42,0x20.
- Address wrap: ADDR_WIDTH=12, BASE_ADDR=0xFFE, word0=0x3C.
  - Writes go to 0xFFE, 0xFFF, 0x000.
- Ignored start: start held high through an entire dump with auto_refresh=0.
  - Exactly one CAPTURE per IDLE entry; no extra writes during EMIT.
  - A second dump begins the cycle after returning to IDLE.
- Auto-refresh: auto_refresh=1 with the basic config.
  - done pulses every 8 cycles; terminal_write is low only in CAPTURE/DONE cycles.
- Reset mid-dump: assert reset (0) during the 3rd write.
  - Next cycle all outputs are 0.
  - After release and start, the first dump shows no highlighted characters.
